// File: rtl/mkio_bus_select.sv
// mkio_bus_select: redundant-channel (A/B) front end of the MKIO remote terminal.
// Locks onto the first active channel, forwards it to the receiver and steers the reply back.
module mkio_bus_select #(
  parameter int SYNC_STAGES = 2,
  parameter int IDLE_CYC    = 96,
  parameter int HOLD_CYC    = 10
) (
  input  logic clk32,
  input  logic reset,
  input  logic DI1A,
  input  logic DI0A,
  input  logic DI1B,
  input  logic DI0B,
  input  logic DO1,
  input  logic DO0,
  input  logic tx_busy,
  output logic DI1,
  output logic DI0,
  output logic DO1A,
  output logic DO0A,
  output logic DO1B,
  output logic DO0B,
  output logic RX_STROB_A,
  output logic RX_STROB_B,
  output logic TX_INHIBIT_A,
  output logic TX_INHIBIT_B,
  output logic active_ch,
  output logic collision,
  output logic line_err_a,
  output logic line_err_b
);

  localparam int SIL_W   = $clog2(IDLE_CYC + 1);
  localparam int HLD_W   = $clog2(HOLD_CYC + 1);
  localparam int ERR_RUN = 4;

  localparam logic [SIL_W-1:0] SIL_LAST  = SIL_W'(IDLE_CYC - 1);
  localparam logic [HLD_W-1:0] HOLD_LAST = HLD_W'(HOLD_CYC - 1);
  localparam logic [2:0]       ERR_FIRE  = 3'(ERR_RUN - 1);
  localparam logic [2:0]       ERR_SAT   = 3'(ERR_RUN);

  typedef enum logic [2:0] {
    IDLE,
    RX_A,
    RX_B,
    TX,
    HOLD
  } state_t;

  // Every registered output lives in one struct so reset and idle defaults are a single constant.
  typedef struct packed {
    logic di1;
    logic di0;
    logic do1a;
    logic do0a;
    logic do1b;
    logic do0b;
    logic strob_a;
    logic strob_b;
    logic inh_a;
    logic inh_b;
    logic ch;
    logic coll;
  } out_t;

  localparam out_t OUT_IDLE = 12'b0000_0011_1100;

  // --------------------------------------------------------------------------
  // Input synchronisers
  // --------------------------------------------------------------------------
  logic [3:0] sync_q [SYNC_STAGES];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      // NOTE: this small array is reset explicitly; only true RAMs are left unreset.
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {DI1A, DI0A, DI1B, DI0B};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  logic s1a, s0a, s1b, s0b;
  logic act_a, act_b;
  logic act_a_q, act_b_q;

  assign {s1a, s0a, s1b, s0b} = sync_q[SYNC_STAGES-1];
  assign act_a = s1a | s0a;
  assign act_b = s1b | s0b;

  // --------------------------------------------------------------------------
  // Lock FSM
  // --------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [SIL_W-1:0] sil_q, sil_d;
  logic [HLD_W-1:0] hold_q, hold_d;
  out_t             out_q, out_d;
  logic             ch_d;
  logic             coll_d;
  logic             own_act;
  logic             oth_rise;

  assign own_act  = (state_q == RX_B) ? act_b : act_a;
  assign oth_rise = (state_q == RX_B) ? (act_a & ~act_a_q) : (act_b & ~act_b_q);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    sil_d   = sil_q;
    hold_d  = hold_q;
    ch_d    = out_q.ch;
    coll_d  = 1'b0;

    case (state_q)
      IDLE: begin
        sil_d = '0;
        if (act_a) begin
          state_d = RX_A;
          ch_d    = 1'b0;
          coll_d  = act_b;
        end else if (act_b) begin
          state_d = RX_B;
          ch_d    = 1'b1;
        end else if (tx_busy) begin
          state_d = TX;
        end
      end
      RX_A, RX_B: begin
        coll_d = oth_rise;
        sil_d  = own_act ? '0 : sil_q + SIL_W'(1);
        if (tx_busy) begin
          state_d = TX;
        end else if (!own_act && sil_q == SIL_LAST) begin
          state_d = IDLE;
        end
      end
      TX: begin
        hold_d = '0;
        if (!tx_busy) state_d = HOLD;
      end
      HOLD: begin
        hold_d = hold_q + HLD_W'(1);
        if (tx_busy) begin
          state_d = TX;
        end else if (hold_q == HOLD_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs decode the next state, so the lock edge already forwards the deciding sample.
    out_d      = OUT_IDLE;
    out_d.ch   = ch_d;
    out_d.coll = coll_d;
    case (state_d)
      RX_A: begin
        out_d.di1 = s1a;
        out_d.di0 = s0a;
      end
      RX_B: begin
        out_d.di1 = s1b;
        out_d.di0 = s0b;
      end
      TX: begin
        if (ch_d) begin
          out_d.do1b    = DO1;
          out_d.do0b    = DO0;
          out_d.inh_b   = 1'b0;
          out_d.strob_b = 1'b0;
        end else begin
          out_d.do1a    = DO1;
          out_d.do0a    = DO0;
          out_d.inh_a   = 1'b0;
          out_d.strob_a = 1'b0;
        end
      end
      HOLD: begin
        if (ch_d) out_d.strob_b = 1'b0;
        else      out_d.strob_a = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sil_q   <= '0;
      hold_q  <= '0;
      out_q   <= OUT_IDLE;
      act_a_q <= 1'b0;
      act_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sil_q   <= sil_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
      act_a_q <= act_a;
      act_b_q <= act_b;
    end
  end

  // --------------------------------------------------------------------------
  // Illegal line state: both lines high for ERR_RUN synced cycles, once per episode
  // --------------------------------------------------------------------------
  logic [2:0] both_cnt_a, both_cnt_b;
  logic       err_a_q, err_b_q;

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      both_cnt_a <= '0;
      both_cnt_b <= '0;
      err_a_q    <= 1'b0;
      err_b_q    <= 1'b0;
    end else begin
      err_a_q <= s1a & s0a & (both_cnt_a == ERR_FIRE);
      err_b_q <= s1b & s0b & (both_cnt_b == ERR_FIRE);

      if (!(s1a & s0a))          both_cnt_a <= '0;
      else if (both_cnt_a != ERR_SAT) both_cnt_a <= both_cnt_a + 3'd1;

      if (!(s1b & s0b))          both_cnt_b <= '0;
      else if (both_cnt_b != ERR_SAT) both_cnt_b <= both_cnt_b + 3'd1;
    end
  end

  assign DI1          = out_q.di1;
  assign DI0          = out_q.di0;
  assign DO1A         = out_q.do1a;
  assign DO0A         = out_q.do0a;
  assign DO1B         = out_q.do1b;
  assign DO0B         = out_q.do0b;
  assign RX_STROB_A   = out_q.strob_a;
  assign RX_STROB_B   = out_q.strob_b;
  assign TX_INHIBIT_A = out_q.inh_a;
  assign TX_INHIBIT_B = out_q.inh_b;
  assign active_ch    = out_q.ch;
  assign collision    = out_q.coll;
  assign line_err_a   = err_a_q;
  assign line_err_b   = err_b_q;

endmodule

// File: doc/mkio_bus_select.md
# mkio_bus_select

Redundant-channel front end of the MKIO remote terminal, sitting between the two bus transceivers (channels A and B) and the single receiver/transmitter pair. It synchronises both channels' input lines and locks onto the channel that becomes active first. The locked channel's line pair is forwarded to the receiver, and the transmitter response is steered back onto that same channel only. It also drives the per-channel receiver-strobe and transmitter-inhibit lines, and flags collisions and illegal line states.

## Interface
Parameters:
- SYNC_STAGES, 2, synchroniser depth on DI1A/DI0A/DI1B/DI0B
- IDLE_CYC, 96, clk32 cycles of silence (3 µs) that release a receive lock
- HOLD_CYC, 10, clk32 cycles the transmit channel's receiver stays disabled after tx_busy falls

Ports:
- clk32  in  1  32 MHz system clock
- reset  in  1  asynchronous, active-high
- DI1A, DI0A, DI1B, DI0B  in  1 each  raw transceiver receive lines
- DO1, DO0  in  1 each  transmitter Manchester outputs
- tx_busy  in  1  transmitter busy, synchronous to clk32
- DI1, DI0  out  1 each  selected-channel lines to receiver
- DO1A, DO0A, DO1B, DO0B  out  1 each  per-channel transmit lines
- RX_STROB_A, RX_STROB_B  out  1 each  1 = channel receiver enabled
- TX_INHIBIT_A, TX_INHIBIT_B  out  1 each  1 = channel transmitter inhibited
- active_ch  out  1  0 = A, 1 = B; channel of current or last lock
- collision  out  1  one-cycle pulse: activity on the non-selected channel
- line_err_a, line_err_b  out  1 each  one-cycle pulse: DI1x and DI0x both high for 4 consecutive synced cycles

## Operation
- Per channel: activity = synced DI1x | DI0x.
- States: IDLE, RX_A, RX_B, TX, HOLD.
- IDLE
  - DI1/DI0 = 0. Both RX_STROB = 1, both TX_INHIBIT = 1.
  - Activity on A → RX_A, active_ch = 0. Activity on B only → RX_B, active_ch = 1.
  - Activity on A and B in the same cycle → RX_A plus a collision pulse.
  - tx_busy = 1 → TX on active_ch.
- RX_x
  - DI1/DI0 = synced lines of channel x.
  - Silence counter clears on any channel-x activity and increments otherwise. Reaching IDLE_CYC → IDLE.
  - Rising edge of activity on the other channel → one collision pulse. The lock is kept.
  - tx_busy = 1 → TX.
- TX
  - DOxA/DOxB: the active_ch pair copies DO1/DO0; the other pair = 0.
  - TX_INHIBIT on active_ch = 0; the other = 1.
  - RX_STROB on active_ch = 0; the other = 1.
  - DI1/DI0 = 0.
  - tx_busy falls → HOLD.
- HOLD
  - Both TX_INHIBIT = 1. DO outputs = 0. RX_STROB on active_ch stays 0.
  - After HOLD_CYC cycles → IDLE.
  - tx_busy rising again during HOLD → TX.
- line_err_x is independent of state. It fires once per episode of both lines high and re-arms when either line drops.
- All outputs are registered.
- Reset values: DI1, DI0, all DO outputs = 0; RX_STROB_A/B = 1; TX_INHIBIT_A/B = 1; active_ch = 0; collision, line_err_a/b = 0; state IDLE; counters 0.
- Reset asserted mid-word or mid-transmit aborts immediately to the reset values.

## Timing
- DIx → DI1/DI0 latency: SYNC_STAGES + 1 = 3 clk32 cycles.
- Lock decision: the first active synced cycle moves the state on the next edge. DI1/DI0 then follow the channel with no lost sample, because the select mux sits in front of the output register.
- DO1/DO0 → DOxx latency: 1 cycle.
- tx_busy → TX_INHIBIT/RX_STROB change: 1 cycle.
- RX exit occurs exactly IDLE_CYC cycles after the last synced activity sample.
- HOLD lasts exactly HOLD_CYC cycles. The RX_STROB on active_ch rises on cycle HOLD_CYC + 1 after tx_busy falls.
- collision and line_err are single-cycle pulses, each asserted 1 cycle after the detecting synced sample.

## Test plan
- Manchester command word on A only (20 bits, 640 cycles) → RX_A; DI1/DI0 equal DI1A/DI0A delayed 3 cycles; state returns to IDLE 96 cycles after the last edge; RX_STROB_A/B stay 1; collision stays 0.
- Word on B, then tx_busy = 1 for 640 cycles → active_ch = 1; DO1B/DO0B mirror DO1/DO0 at 1 cycle; DO1A/DO0A = 0; TX_INHIBIT_B = 0 and TX_INHIBIT_A = 1; RX_STROB_B = 0 for 640 + 10 cycles; RX_STROB_A = 1 throughout.
- A and B go active in the same cycle → lock on A with one collision pulse; B pulse trains during the A word → one collision pulse per B activity onset.
- DI1A = DI0A = 1 held for 10 cycles → exactly one line_err_a pulse, on the cycle after the 4th consecutive synced cycle; line_err_b stays 0.
- tx_busy re-asserted on HOLD cycle 5 → back to TX on the same channel; TX_INHIBIT released again 1 cycle later.
- reset pulsed mid-transmit → all outputs at reset values within the same cycle (asynchronous); after release, a word on A locks normally.
